// File: rtl/embedded_sync_decoder_pkg.sv
// Shared constants, state encoding and XY protection helper
// for the embedded-sync (SAV/EAV) stream decoder.
package embedded_sync_decoder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ONES  = 2'd1;
  localparam logic [1:0] ST_ZEROS = 2'd2;
  localparam logic [1:0] ST_XY    = 2'd3;

  localparam logic [9:0] PAT_ONES  = 10'h3FF;
  localparam logic [9:0] PAT_ZEROS = 10'h000;

  localparam int XY_B1 = 7;
  localparam int XY_F  = 6;
  localparam int XY_V  = 5;
  localparam int XY_H  = 4;

  function automatic logic [3:0] xy_prot(
    input logic f,
    input logic v,
    input logic h
  );
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/embedded_sync_decoder_sync_code_matcher.sv
// Preamble FSM (ones x R, zeros x 2R, XY x R) with XY decode
// and protection check; code pulses are combinational.
module sync_code_matcher
  import embedded_sync_decoder_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_REPEAT = 2,
  parameter int ECC_CHECK   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_code_valid,
  output logic              o_code_err,
  output logic              o_f,
  output logic              o_v,
  output logic              o_h
);

  localparam logic [3:0] C_R   = 4'(SYNC_REPEAT);
  localparam logic [3:0] C_RM1 = 4'(SYNC_REPEAT - 1);
  localparam logic [3:0] C_ZM1 = 4'(2 * SYNC_REPEAT - 1);

  logic [1:0] r_st;
  logic [3:0] r_cnt;
  logic [1:0] w_st_nx;
  logic [3:0] w_cnt_nx;
  logic       w_dec;
  logic       w_ones;
  logic       w_zero;
  logic       w_ok;
  logic [7:0] w_xy;

  assign w_ones = (i_data == PAT_ONES[DATA_W-1:0]);
  assign w_zero = (i_data == PAT_ZEROS[DATA_W-1:0]);
  assign w_xy   = i_data[DATA_W-1 -: 8];
  assign o_f    = w_xy[XY_F];
  assign o_v    = w_xy[XY_V];
  assign o_h    = w_xy[XY_H];

  assign w_ok = (ECC_CHECK == 0) ||
                (w_xy[XY_B1] &&
                 (w_xy[3:0] == xy_prot(o_f, o_v, o_h)));

  assign o_code_valid = i_en & w_dec & w_ok;
  assign o_code_err   = i_en & w_dec & ~w_ok;

  // Next-state logic; an all-ones mismatch resyncs into ONES
  always_comb begin
    w_st_nx  = ST_IDLE;
    w_cnt_nx = '0;
    w_dec    = 1'b0;
    unique case (r_st)
      ST_IDLE: begin
        if (w_ones) begin
          w_st_nx  = ST_ONES;
          w_cnt_nx = 4'd1;
        end
      end
      ST_ONES: begin
        if (w_ones && (r_cnt < C_R)) begin
          w_st_nx  = ST_ONES;
          w_cnt_nx = r_cnt + 4'd1;
        end else if (w_zero && (r_cnt == C_R)) begin
          w_st_nx  = ST_ZEROS;
          w_cnt_nx = 4'd1;
        end else if (w_ones) begin
          w_st_nx  = ST_ONES;
          w_cnt_nx = 4'd1;
        end
      end
      ST_ZEROS: begin
        if (w_zero) begin
          if (r_cnt == C_ZM1) begin
            w_st_nx = ST_XY;
          end else begin
            w_st_nx  = ST_ZEROS;
            w_cnt_nx = r_cnt + 4'd1;
          end
        end else if (w_ones) begin
          w_st_nx  = ST_ONES;
          w_cnt_nx = 4'd1;
        end
      end
      ST_XY: begin
        if (r_cnt == C_RM1) begin
          w_dec = 1'b1;
        end else begin
          w_st_nx  = ST_XY;
          w_cnt_nx = r_cnt + 4'd1;
        end
      end
    endcase
  end

  // State register, advances only on enabled words
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st  <= ST_IDLE;
      r_cnt <= '0;
    end else if (i_en) begin
      r_st  <= w_st_nx;
      r_cnt <= w_cnt_nx;
    end
  end

endmodule

// File: rtl/embedded_sync_decoder.sv
// Embedded-sync stream decoder: registered data with aligned
// FV/LV, field, line count and sync/length error pulses.
module embedded_sync_decoder
  import embedded_sync_decoder_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int SYNC_REPEAT  = 2,
  parameter int ACTIVE_WORDS = 3840,
  parameter int CNT_W        = 13,
  parameter int LINE_W       = 12,
  parameter int ECC_CHECK    = 1
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              FV,
  output logic              LV,
  output logic              field,
  output logic [LINE_W-1:0] line_count,
  output logic              sync_err,
  output logic              len_err
);

  localparam int EAV_LEN = ACTIVE_WORDS + 4 * SYNC_REPEAT;
  localparam logic [CNT_W-1:0] C_EAV_LAST = CNT_W'(EAV_LEN - 1);
  localparam logic [CNT_W-1:0] C_AW = CNT_W'(ACTIVE_WORDS);

  logic              w_cv;
  logic              w_ce;
  logic              w_f;
  logic              w_v;
  logic              w_h;
  logic              w_sav;
  logic              w_eav;
  logic [DATA_W-1:0] r_dout;
  logic              r_fv;
  logic              r_lv;
  logic              r_arm;
  logic              r_field;
  logic [LINE_W-1:0] r_lc;
  logic [CNT_W-1:0]  r_wcnt;
  logic [CNT_W-1:0]  r_lvcnt;
  logic              r_serr;
  logic              r_lerr;

  sync_code_matcher #(
    .DATA_W      (DATA_W),
    .SYNC_REPEAT (SYNC_REPEAT),
    .ECC_CHECK   (ECC_CHECK)
  ) u_match (
    .i_clk        (clock_in),
    .i_rst        (reset),
    .i_en         (pix_en),
    .i_data       (data_in),
    .o_code_valid (w_cv),
    .o_code_err   (w_ce),
    .o_f          (w_f),
    .o_v          (w_v),
    .o_h          (w_h)
  );

  assign w_sav = w_cv & ~w_h;
  assign w_eav = w_cv & w_h;

  // One-word data delay
  always_ff @(posedge clock_in) begin
    if (reset) r_dout <= '0;
    else if (pix_en) r_dout <= data_in;
  end

  // Frame state: field, FV and active-line count
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_field <= 1'b0;
      r_fv    <= 1'b0;
      r_lc    <= '0;
    end else if (w_cv) begin
      r_field <= w_f;
      if (w_v && r_fv) begin
        r_fv <= 1'b0;
      end else if (w_sav && !w_v && !r_fv) begin
        r_fv <= 1'b1;
        r_lc <= '0;
      end
      if (w_eav && !w_v && r_fv && (r_lc != '1))
        r_lc <= r_lc + 1'b1;
    end
  end

  // LV window: armed by active SAV, opens on the next word
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_arm   <= 1'b0;
      r_lv    <= 1'b0;
      r_lvcnt <= '0;
    end else if (pix_en) begin
      r_arm <= w_sav & ~w_v;
      if (w_sav) begin
        r_lv <= 1'b0;
      end else if (r_arm) begin
        r_lv    <= 1'b1;
        r_lvcnt <= CNT_W'(1);
      end else if (r_lv) begin
        if (r_lvcnt == C_AW) r_lv <= 1'b0;
        else r_lvcnt <= r_lvcnt + 1'b1;
      end
    end
  end

  // Saturating word count since the last SAV
  always_ff @(posedge clock_in) begin
    if (reset) r_wcnt <= '0;
    else if (pix_en) begin
      if (w_sav) r_wcnt <= '0;
      else if (r_wcnt != '1) r_wcnt <= r_wcnt + 1'b1;
    end
  end

  // Error pulses, cleared on every edge without an event
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_serr <= 1'b0;
      r_lerr <= 1'b0;
    end else begin
      r_serr <= w_ce;
      r_lerr <= (w_sav & r_lv) |
                (w_eav & (r_wcnt != C_EAV_LAST));
    end
  end

  assign data_out   = r_dout;
  assign FV         = r_fv;
  assign LV         = r_lv;
  assign field      = r_field;
  assign line_count = r_lc;
  assign sync_err   = r_serr;
  assign len_err    = r_lerr;

endmodule

// File: doc/embedded_sync_decoder.md
Name: embedded_sync_decoder

Overview:
- Parametrised successor to the Sony block-camera parallel interface decoder.
- Consumes a byte/word stream already serialised into the clock_in domain, in BT.656/BT.1120 style with SAV/EAV codes embedded in the data.
- Each code word may be repeated SYNC_REPEAT times, which covers interleaved 16-bit sources.
- Outputs a registered data stream with aligned FV/LV for the CSI-2 packer, plus field, line count and error pulses.

Parameters:
- DATA_W, 8: stream word width, 8 or 10. The XY code is taken from the top 8 bits.
- SYNC_REPEAT, 2: number of consecutive copies of each code word (1..4).
- ACTIVE_WORDS, 3840: number of LV-high words per active line.
- CNT_W, 13: width of the word counter. Must satisfy 2^CNT_W > ACTIVE_WORDS + 4*SYNC_REPEAT.
- LINE_W, 12: width of line_count.
- ECC_CHECK, 1: when 1, reject XY codes whose protection bits are wrong.

Ports:
- clock_in, input, 1: pixel-word clock. The only clock.
- reset, input, 1: synchronous, active-high.
- pix_en, input, 1: word-valid qualifier. When 0, all state holds.
- data_in, input, DATA_W: incoming stream.
- data_out, output, DATA_W: data_in delayed by one enabled word.
- FV, output, 1: frame valid.
- LV, output, 1: line valid, aligned with data_out.
- field, output, 1: F bit of the last accepted code.
- line_count, output, LINE_W: active lines in the current frame.
- sync_err, output, 1: one-cycle pulse on an XY code with a protection failure.
- len_err, output, 1: one-cycle pulse on a line-length mismatch.

Behaviour:
- Reset values: data_out=0, FV=0, LV=0, field=0, line_count=0, sync_err=0, len_err=0. The FSM goes to IDLE. This applies mid-line too: everything is cleared on the next edge.
- All updates happen only on edges with pix_en=1. With pix_en=0, every register holds and error pulses are 0.
- Preamble: R=SYNC_REPEAT. The sequence is all-ones ×R, then all-zeros ×2R, then XY ×R.
- FSM states: IDLE, ONES, ZEROS, XY, with an internal repeat counter.
  - IDLE -> ONES on an all-ones word.
  - ONES -> ZEROS after R all-ones words, then on the first all-zeros word.
  - ZEROS -> XY after 2R all-zeros words.
  - In XY, the first R-1 copies are skipped. The R-th copy is decoded, then the FSM returns to IDLE.
- Any mismatch returns the FSM to IDLE. Exception: if the mismatching word is all-ones, go to ONES with count 1 (resync).
- XY decode:
  - bit7 must be 1. F=bit6, V=bit5, H=bit4. H=0 means SAV, H=1 means EAV.
  - Protection bits: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
  - If ECC_CHECK=1 and bit7=0 or any P bit is wrong: pulse sync_err and ignore the code.
  - With ECC_CHECK=0, every code is accepted.
- Accepted code: field<=F.
- FV:
  - If V=1 and FV=1: FV<=0 on the decode edge. line_count holds until the next frame start.
  - If SAV with V=0 and FV=0: FV<=1 and line_count<=0.
- LV:
  - SAV with V=0 arms LV. LV=1 starts on the following enabled edge, together with the word immediately after XY appearing on data_out.
  - LV stays high for exactly ACTIVE_WORDS enabled words, then drops. A SAV with V=1 never raises LV.
- Word counter:
  - Cleared at SAV decode; counts data_in words after it.
  - At EAV decode, the count including the EAV's XY word must equal ACTIVE_WORDS+4R. Otherwise pulse len_err.
  - The counter saturates at its maximum value and does not wrap.
- EAV with V=0 and FV=1: line_count increments, saturating at 2^LINE_W-1.
- A SAV decoded while LV is still high: pulse len_err and restart the LV window from 0.
- Latency: data_out, LV and FV are one enabled cycle after data_in.

Decomposition:
- Shared package:
  - preamble constants (ONES/ZEROS patterns per DATA_W);
  - XY bit positions;
  - FSM state encoding;
  - protection-bit function.
- One natural sub-module, sync_code_matcher: the preamble FSM plus XY decode and protection check. Outputs a code_valid pulse with F/V/H and a code_err pulse.
- The top level keeps FV/LV, the counters and the data pipeline.

Test Plan:
- R=2, DATA_W=8, ACTIVE_WORDS=16: send FF FF 00 00 00 00 80 80 then 16 pixels 01..10, then EAV FF FF 00 00 00 00 9D 9D. Expect FV rising with the SAV; LV high for exactly 16 cycles with data_out 01..10; line_count=1; no len_err.
- Protection error: send XY=0x81 after a valid preamble with ECC_CHECK=1. Expect a sync_err pulse and no change in FV, LV or field. With ECC_CHECK=0, no pulse.
- Vertical blanking: send SAV 0xAB while FV=1. Expect FV to fall on the decode edge, LV to stay 0, and line_count to hold.
- Short line: EAV arrives after 12 pixels. Expect a len_err pulse at EAV decode. Also send a second SAV while LV is high: expect len_err and LV restarting for 16 words.
- Resync: send FF 00 FF FF 00 00 00 00 80 80. The stray FF restarts the match and the line is decoded. Also toggle pix_en=0 for 3 cycles mid-line: outputs hold and the LV length stays 16 enabled words.
- Reset asserted mid-line with LV=1: all outputs are 0 on the next edge, and the next valid SAV starts normally.
